// File: rtl/reg_alu_ctrl_pkg.sv
// Shared definitions for the register-file ALU controller.
// Holds the widths, the op/kind/state encodings and the command payload.
package reg_alu_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_N  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic {
    KIND_ALU   = 1'b0,
    KIND_LOADI = 1'b1
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Command captured at the accepting edge.
  typedef struct packed {
    kind_e             kind;
    op_e               op;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs1;
    logic [IDX_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
  } cmd_t;

endpackage

// File: rtl/reg_alu_ctrl_alu_exec.sv
// Combinational result evaluation for one command.
// Ports: i_op/i_kind select the operation, i_a/i_b are the latched operands,
//        i_imm the load immediate; o_result/o_cout are the result and carry.
module alu_exec
  import reg_alu_ctrl_pkg::*;
(
  input  op_e               i_op,
  input  kind_e             i_kind,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_cout
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum    = '0;
    o_result = '0;
    o_cout   = 1'b0;
    if (i_kind == KIND_LOADI) begin
      o_result = i_imm;
    end else begin
      case (i_op)
        OP_AND: o_result = i_a & i_b;
        OP_OR:  o_result = i_a | i_b;
        OP_ADD: begin
          w_sum    = {1'b0, i_a} + {1'b0, i_b};
          o_result = w_sum[DATA_W-1:0];
          o_cout   = w_sum[DATA_W];
        end
        OP_SUB: begin
          // Two's-complement subtract; carry out is the "no borrow" flag (A >= B).
          w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + (DATA_W+1)'(1);
          o_result = w_sum[DATA_W-1:0];
          o_cout   = w_sum[DATA_W];
        end
        default: o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/reg_alu_ctrl.sv
// Register-file ALU controller: accepts one command at a time, reads two
// operands, evaluates, writes back and presents the result with handshake.
// Ports: clk/reset (sync, active high); in_* command handshake and payload;
//        out_* result handshake (data, carry, destination);
//        dbg_addr/dbg_data combinational register-file read.
module reg_alu_ctrl
  import reg_alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kind,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic [IDX_W-1:0]  in_rs1,
  input  logic [IDX_W-1:0]  in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_cout,
  output logic [IDX_W-1:0]  out_rd,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            r_state;
  state_e            w_state_nxt;
  cmd_t              r_cmd;
  cmd_t              w_cmd_in;
  logic [DATA_W-1:0] r_rf [REG_N];
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_cout;
  logic [IDX_W-1:0]  r_out_rd;
  logic              w_accept;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_cout;

  assign w_accept = in_valid & r_in_ready;

  assign w_cmd_in = '{kind: kind_e'(in_kind), op: op_e'(in_op), rd: in_rd,
                      rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, register file, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_rf        <= '{default: '0};
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cout  <= 1'b0;
      r_out_rd    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) r_cmd <= w_cmd_in;
      // Operands are latched before write-back, so rd aliasing rs1/rs2 sees old values.
      if (r_state == S_READ) begin
        r_op_a <= r_rf[r_cmd.rs1];
        r_op_b <= r_rf[r_cmd.rs2];
      end
      if (r_state == S_EXEC) begin
        r_out_data       <= w_alu_res;
        r_out_cout       <= w_alu_cout;
        r_out_rd         <= r_cmd.rd;
        r_out_valid      <= 1'b1;
        r_rf[r_cmd.rd]   <= w_alu_res;
      end
      if ((r_state == S_RESP) && out_ready) r_out_valid <= 1'b0;
    end
  end

  alu_exec u_alu_exec (
    .i_op     (r_cmd.op),
    .i_kind   (r_cmd.kind),
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .i_imm    (r_cmd.imm),
    .o_result (w_alu_res),
    .o_cout   (w_alu_cout)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_cout  = r_out_cout;
  assign out_rd    = r_out_rd;
  assign dbg_data  = r_rf[dbg_addr];

endmodule
